seq_divider: RTL and testbench

//   Unsigned sequential restoring divider (shift-subtract), the inverse companion of the shift-add multiplier.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 93 +++++++++
 tb/tb_seq_divider.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Control handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: one quotient bit per clock, start/busy/done control.
module seq_divider #(
  parameter int unsigned N = 4
) (
  input  logic        i_clk,
  input  logic        i_clr,
  seq_divider_if.slave div
);

  localparam int unsigned   CW      = $clog2(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_rem_out;
  logic          r_dbz;

  logic [N:0]    w_t;
  logic [N:0]    w_sub;
  logic          w_ge;
  logic [N-1:0]  w_rem_next;
  logic [N-1:0]  w_q_next;

  // The partial remainder stays below the divisor, so its top bit is always zero and is
  // not stored; the (N+1)-bit difference's sign bit serves as the T >= D comparison.
  always_comb begin
    w_t        = {r_rem, r_q[N-1]};
    w_sub      = w_t - {1'b0, r_d};
    w_ge       = ~w_sub[N];
    w_rem_next = w_ge ? w_sub[N-1:0] : w_t[N-1:0];
    w_q_next   = {r_q[N-2:0], w_ge};
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div.start) begin
            if (div.divisor != '0) begin
              r_rem   <= '0;
              r_q     <= div.dividend;
              r_d     <= div.divisor;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end else begin
              r_quot    <= '1;
              r_rem_out <= div.dividend;
              r_dbz     <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            r_quot    <= w_q_next;
            r_rem_out <= w_rem_next;
            r_dbz     <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div.busy        = (r_state != S_IDLE);
  assign div.done        = (r_state == S_DONE);
  assign div.quotient    = r_quot;
  assign div.remainder   = r_rem_out;
  assign div.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain integer division.
module tb_seq_divider;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .div   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a division at the current negedge (block must be idle) and checks the whole
  // transaction. With hold set, start stays high with other operands through CALC and DONE.
  task automatic do_div(input int a, input int b, input bit hold);
    int eq, er, ed, elat, edges;
    eq   = (b == 0) ? (1 << N) - 1 : a / b;
    er   = (b == 0) ? a : a % b;
    ed   = (b == 0) ? 1 : 0;
    elat = (b == 0) ? 1 : N + 1;
    chk("idle_before_start", {31'd0, bus.busy}, 32'd0);
    bus.start    = 1'b1;
    bus.dividend = a[N-1:0];
    bus.divisor  = b[N-1:0];
    @(posedge clk);
    #1;
    if (hold) begin
      bus.dividend = 4'd6;
      bus.divisor  = 4'd2;
    end else begin
      bus.start    = 1'b0;
      bus.dividend = N'($urandom);
      bus.divisor  = N'($urandom);
    end
    edges = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || edges >= 20) break;
      @(posedge clk);
      edges++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    chk("latency", edges, elat);
    chk("quotient", {28'd0, bus.quotient}, eq);
    chk("remainder", {28'd0, bus.remainder}, er);
    chk("div_by_zero", {31'd0, bus.div_by_zero}, ed);
    chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
    if (hold) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
    end else begin
      bus.start = 1'b0;
    end
    @(negedge clk);
    chk("done_width", {31'd0, bus.done}, 32'd0);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    chk("quotient_hold", {28'd0, bus.quotient}, eq);
    chk("remainder_hold", {28'd0, bus.remainder}, er);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_quotient", {28'd0, bus.quotient}, 32'd0);
    chk("rst_remainder", {28'd0, bus.remainder}, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Directed cases
    do_div(13, 3, 1'b0);
    do_div(15, 1, 1'b0);
    do_div(5, 7, 1'b0);
    do_div(15, 15, 1'b0);
    do_div(0, 9, 1'b0);
    do_div(9, 0, 1'b0);
    do_div(8, 2, 1'b0);

    // Start pulses during CALC and DONE are ignored; results then hold in IDLE
    do_div(13, 3, 1'b1);
    @(negedge clk);
    chk("idle_hold_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_hold_q", {28'd0, bus.quotient}, 32'd4);
    chk("idle_hold_r", {28'd0, bus.remainder}, 32'd1);

    // Reset on the second CALC edge abandons the division
    bus.start    = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor  = 4'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_done_pre", {31'd0, bus.done}, 32'd0);
    clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_quotient", {28'd0, bus.quotient}, 32'd0);
    chk("abort_remainder", {28'd0, bus.remainder}, 32'd0);
    chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    clr = 1'b1;
    @(negedge clk);
    do_div(14, 4, 1'b0);

    // Exhaustive sweep of every operand pair
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        do_div(a, b, 1'b0);
      end
    end

    // Randomized operands
    repeat (40) begin
      do_div(int'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(0, (1 << N) - 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
